// File: rtl/sec_dec_locked_pipe.sv
// sec_dec_locked_pipe
//
// Purpose:
//   Pipelined single-error-correcting Hamming decoder whose corrected output
//   bits CAM_BASE..CAM_BASE+NCAM-1 go through key-locked camouflaged cells.
//   Each cell is the correct XOR only when its 2-bit key pair has bit 0 set.
//   Key pair 00 turns the cell into NAND, and key pair 10 turns it into NOR.
//   The key is shifted in serially into a shadow register. It is then copied
//   into the active register once both pipeline stages have drained, so no
//   word in flight ever sees a mixed key.
//
// Configuration macro:
//   SECDEC_DED_EN - adds an overall parity bit in_chk[CHK_W] and turns on
//                   double-error detection. When the macro is undefined the
//                   decoder is plain SEC.
//
// Parameters:
//   DATA_W   data bits per word
//   CHK_W    Hamming check bits (2**CHK_W >= DATA_W+CHK_W+1)
//   NCAM     number of camouflaged output cells
//   CAM_BASE first output bit carrying a cell (CAM_BASE+NCAM <= DATA_W)
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   key_in, key_vld serial key bit (LSB first) and its qualifier
//   key_busy        key load or drain in progress
//   in_vld, in_rdy  input handshake
//   in_data, in_chk received word and check bits
//   in_en           correction enable (syndrome still reported when 0)
//   out_vld, out_rdy output handshake
//   out_data        corrected data after the cells
//   out_syn         syndrome
//   out_err         00 clean, 01 data corrected, 10 check-bit error,
//                   11 uncorrectable
module sec_dec_locked_pipe #(
  parameter int DATA_W   = 32,
  parameter int CHK_W    = 6,
  parameter int NCAM     = 1,
  parameter int CAM_BASE = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_in,
  input  logic              key_vld,
  output logic              key_busy,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [DATA_W-1:0] in_data,
`ifdef SECDEC_DED_EN
  input  logic [CHK_W:0]    in_chk,
`else
  input  logic [CHK_W-1:0]  in_chk,
`endif
  input  logic              in_en,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_data,
  output logic [CHK_W-1:0]  out_syn,
  output logic [1:0]        out_err
);

  localparam int KEY_BITS = 2 * NCAM;
  localparam int CNT_W    = $clog2(KEY_BITS + 1);

  localparam logic [1:0] ERR_CLEAN  = 2'b00;
  localparam logic [1:0] ERR_DATA   = 2'b01;
  localparam logic [1:0] ERR_CHECK  = 2'b10;
  localparam logic [1:0] ERR_UNCORR = 2'b11;

  typedef enum logic [1:0] {
    KEY_IDLE,
    KEY_LOAD,
    KEY_DRAIN
  } key_state_t;

  // Column of data bit idx: the idx-th integer >= 3 that is not a power of
  // two. Powers of two are reserved for the check bits themselves.
  function automatic logic [CHK_W-1:0] h_col(input int idx);
    logic [CHK_W-1:0] res;
    int               n;
    res = '0;
    n   = 0;
    for (int c = 3; c < (1 << CHK_W); c++) begin
      if ((c & (c - 1)) != 0) begin
        if (n == idx) res = c[CHK_W-1:0];
        n++;
      end
    end
    return res;
  endfunction

  // Camouflaged cell: key bit 0 selects the true XOR; otherwise key bit 1
  // chooses between the NOR and NAND decoys.
  function automatic logic cam_cell(input logic a, input logic b,
                                    input logic [1:0] k);
    logic r;
    if (k[0])      r = a ^ b;
    else if (k[1]) r = ~(a | b);
    else           r = ~(a & b);
    return r;
  endfunction

  // Constant column table.
  logic [CHK_W-1:0] h_tab [DATA_W];

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_col
    localparam logic [CHK_W-1:0] HC = h_col(gi);
    assign h_tab[gi] = HC;
  end

  // Key state and pipeline registers.
  key_state_t            state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [KEY_BITS-1:0]   shadow, shadow_n;
  logic [KEY_BITS-1:0]   key_act;
  logic                  commit;

  logic                  v1;
  logic [CHK_W-1:0]      syn1;
  logic [1:0]            err1;
  logic [DATA_W-1:0]     data1;
  logic                  en1;

  logic                  adv2;
  logic                  accept;

  // Stage-0 decode signals.
  logic [CHK_W-1:0]      col_xor;
  logic [CHK_W-1:0]      syn0;
  logic                  any_match;
  logic                  syn_pow2;
  logic [1:0]            err_base;
  logic [1:0]            err0;
`ifdef SECDEC_DED_EN
  logic                  par_err;
`endif

  // Stage-1 to stage-2 correction signals.
  logic [DATA_W-1:0]     flip;
  logic [DATA_W-1:0]     corr;

  // Handshake. Stage 2 can take a word when it is empty or is being drained.
  // New words are refused while a key is loading or draining, and during
  // the reset cycle.
  assign adv2     = !out_vld || out_rdy;
  assign in_rdy   = !rst && (state == KEY_IDLE) && (!v1 || adv2);
  assign accept   = in_vld && in_rdy;
  assign key_busy = (state != KEY_IDLE);

  // Syndrome and error classification of the incoming word.
  always_comb begin
    col_xor = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (in_data[i]) col_xor = col_xor ^ h_tab[i];
    end
    syn0 = in_chk[CHK_W-1:0] ^ col_xor;

    any_match = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (syn0 == h_tab[i]) any_match = 1'b1;
    end
    syn_pow2 = (syn0 != '0) && ((syn0 & (syn0 - CHK_W'(1))) == '0);

    if (syn0 == '0)    err_base = ERR_CLEAN;
    else if (any_match) err_base = ERR_DATA;
    else if (syn_pow2)  err_base = ERR_CHECK;
    else                err_base = ERR_UNCORR;

`ifdef SECDEC_DED_EN
    // An even overall parity with a nonzero syndrome means two bits flipped.
    par_err = (^in_data) ^ (^in_chk);
    if (syn0 == '0)    err0 = par_err ? ERR_CHECK : ERR_CLEAN;
    else if (!par_err) err0 = ERR_UNCORR;
    else               err0 = err_base;
`else
    err0 = err_base;
`endif
  end

  // Stage 1 advances whenever it is empty or stage 2 can accept its word.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      syn1  <= '0;
      err1  <= ERR_CLEAN;
      data1 <= '0;
      en1   <= 1'b0;
    end else if (!v1 || adv2) begin
      v1 <= accept;
      if (accept) begin
        syn1  <= syn0;
        err1  <= err0;
        data1 <= in_data;
        en1   <= in_en;
      end
    end
  end

  // Flip requests only for a correctable data error with correction enabled.
  // Plain bits use XOR. Bits under a cell use the keyed cell with the
  // active key.
  for (genvar gj = 0; gj < DATA_W; gj++) begin : g_bit
    assign flip[gj] = en1 && (err1 == ERR_DATA) && (syn1 == h_tab[gj]);
    if (gj >= CAM_BASE && gj < CAM_BASE + NCAM) begin : g_cam
      assign corr[gj] = cam_cell(data1[gj], flip[gj],
                                 key_act[2*(gj-CAM_BASE) +: 2]);
    end else begin : g_xor
      assign corr[gj] = data1[gj] ^ flip[gj];
    end
  end

  // Stage 2 holds its contents while out_vld is high and out_rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_syn  <= '0;
      out_err  <= ERR_CLEAN;
    end else if (adv2) begin
      out_vld <= v1;
      if (v1) begin
        out_data <= corr;
        out_syn  <= syn1;
        out_err  <= err1;
      end
    end
  end

  // Key FSM state register. Reset drops any partial key and clears the
  // active key.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= KEY_IDLE;
      cnt     <= '0;
      shadow  <= '0;
      key_act <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      shadow <= shadow_n;
      if (commit) key_act <= shadow;
    end
  end

  // Key FSM next state. Bits enter at the top and shift down, so the first
  // bit received ends up in bit 0.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    shadow_n = shadow;
    commit   = 1'b0;
    case (state)
      KEY_IDLE: begin
        if (key_vld) begin
          shadow_n = {key_in, shadow[KEY_BITS-1:1]};
          cnt_n    = CNT_W'(1);
          state_n  = KEY_LOAD;
        end
      end
      KEY_LOAD: begin
        if (key_vld) begin
          shadow_n = {key_in, shadow[KEY_BITS-1:1]};
          cnt_n    = cnt + CNT_W'(1);
          if (cnt == CNT_W'(KEY_BITS - 1)) state_n = KEY_DRAIN;
        end
      end
      KEY_DRAIN: begin
        if (!v1 && !out_vld) begin
          commit  = 1'b1;
          cnt_n   = '0;
          state_n = KEY_IDLE;
        end
      end
      default: begin
        state_n = KEY_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sec_dec_locked_pipe.sv
// tb_sec_dec_locked_pipe
//
// Directed bench for sec_dec_locked_pipe with the default parameters
// (32 data bits, 6 check bits, one cell on bit 19).
// Data bit columns: bit 0 -> 3, 1 -> 5, 2 -> 6, 3 -> 7, 4 -> 9, 19 -> 25,
// 30 -> 37, 31 -> 38.
module tb_sec_dec_locked_pipe;

`ifdef SECDEC_DED_EN
  localparam int CHK_IN_W = 7;
`else
  localparam int CHK_IN_W = 6;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                key_in;
  logic                key_vld;
  logic                key_busy;
  logic                in_vld;
  logic                in_rdy;
  logic [31:0]         in_data;
  logic [CHK_IN_W-1:0] in_chk;
  logic                in_en;
  logic                out_vld;
  logic                out_rdy;
  logic [31:0]         out_data;
  logic [5:0]          out_syn;
  logic [1:0]          out_err;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0] data;
    logic [5:0]  chk;
    logic        en;
    logic [31:0] exp_data;
    logic [5:0]  exp_syn;
    logic [1:0]  exp_err;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  sec_dec_locked_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .key_in   (key_in),
    .key_vld  (key_vld),
    .key_busy (key_busy),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_data  (in_data),
    .in_chk   (in_chk),
    .in_en    (in_en),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .out_syn  (out_syn),
    .out_err  (out_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Send one word with out_rdy high and return the output word together
  // with the number of cycles from acceptance to out_vld.
  task automatic applyStimulus(input logic [31:0] data, input logic [5:0] chk,
                               input logic en, output logic [31:0] got_data,
                               output logic [5:0] got_syn,
                               output logic [1:0] got_err, output int lat);
    int waitc;
    got_data = '0;
    got_syn  = '0;
    got_err  = '0;
    lat      = -1;
    @(negedge clk);
    out_rdy = 1'b1;
    in_vld  = 1'b1;
    in_data = data;
    in_chk  = CHK_IN_W'(chk);
    in_en   = en;
    #1;
    waitc = 0;
    while (!in_rdy && waitc < 50) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    if (!in_rdy) begin
      checkOutput("accept_timeout", 32'(in_rdy), 32'd1);
      in_vld = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_vld = 1'b0;
    lat    = 1;
    while (!out_vld && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got_data = out_data;
    got_syn  = out_syn;
    got_err  = out_err;
  endtask

  task automatic loadKey(input logic [1:0] key);
    int waitc;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      key_vld = 1'b1;
      key_in  = key[i];
    end
    @(negedge clk);
    key_vld = 1'b0;
    waitc   = 0;
    while (key_busy && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    checkOutput("key_load_done", 32'(key_busy), 32'd0);
  endtask

  initial begin
    #500000;
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] gd;
    logic [5:0]  gs;
    logic [1:0]  ge;
    int          lat;
    logic [31:0] stall_data [4];
    logic [5:0]  stall_chk  [4];
    int          sent;
    int          rcvd;
    logic [31:0] held;
    logic        was_stalled;
    logic        acc;
    logic [31:0] rx [2];
    int          rx_n;
    int          waitc;

    // Vectors applied with the key set to 01, so the cell acts as XOR.
    vecs[0]  = '{32'h00000000, 6'd0,  1'b1, 32'h00000000, 6'd0,  2'b00};
    vecs[1]  = '{32'h00000008, 6'd0,  1'b1, 32'h00000000, 6'd7,  2'b01};
    vecs[2]  = '{32'h00000008, 6'd0,  1'b0, 32'h00000008, 6'd7,  2'b01};
    vecs[3]  = '{32'h00000000, 6'd4,  1'b1, 32'h00000000, 6'd4,  2'b10};
    vecs[4]  = '{32'h00000003, 6'd0,  1'b1, 32'h00000007, 6'd6,  2'b01};
    vecs[5]  = '{32'h00080000, 6'd25, 1'b1, 32'h00080000, 6'd0,  2'b00};
    vecs[6]  = '{32'h00000000, 6'd25, 1'b1, 32'h00080000, 6'd25, 2'b01};
    vecs[7]  = '{32'h00000000, 6'd25, 1'b0, 32'h00000000, 6'd25, 2'b01};
    vecs[8]  = '{32'h80000000, 6'd38, 1'b1, 32'h80000000, 6'd0,  2'b00};
    vecs[9]  = '{32'h80000001, 6'd0,  1'b1, 32'hC0000001, 6'd37, 2'b01};
    vecs[10] = '{32'h00000000, 6'd39, 1'b1, 32'h00000000, 6'd39, 2'b11};
    vecs[11] = '{32'h00000000, 6'd32, 1'b1, 32'h00000000, 6'd32, 2'b10};
    vecs[12] = '{32'h00000010, 6'd8,  1'b1, 32'h00000010, 6'd1,  2'b10};
    vecs[13] = '{32'h00000010, 6'd9,  1'b1, 32'h00000010, 6'd0,  2'b00};

    stall_data = '{32'h1, 32'h2, 32'h4, 32'h8};
    stall_chk  = '{6'd3, 6'd5, 6'd6, 6'd7};

    rst     = 1'b1;
    key_in  = 1'b0;
    key_vld = 1'b0;
    in_vld  = 1'b0;
    in_data = '0;
    in_chk  = '0;
    in_en   = 1'b1;
    out_rdy = 1'b1;

    // Reset state, sampled while reset is still asserted.
    @(negedge clk);
    checkOutput("reset_in_rdy",   32'(in_rdy),   32'd0);
    checkOutput("reset_out_vld",  32'(out_vld),  32'd0);
    checkOutput("reset_out_data", out_data,      32'h0);
    checkOutput("reset_out_syn",  32'(out_syn),  32'd0);
    checkOutput("reset_out_err",  32'(out_err),  32'd0);
    checkOutput("reset_key_busy", 32'(key_busy), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("idle_in_rdy", 32'(in_rdy), 32'd1);

    // Before any key load the cell is NAND: 0 NAND 0 drives bit 19 high.
    applyStimulus(32'h0, 6'd0, 1'b1, gd, gs, ge, lat);
    checkOutput("nokey_data",    gd,        32'h00080000);
    checkOutput("nokey_err",     32'(ge),   32'd0);
    checkOutput("nokey_latency", 32'(lat),  32'd2);

    loadKey(2'b01);

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].data, vecs[i].chk, vecs[i].en, gd, gs, ge, lat);
      checkOutput($sformatf("vec%0d_data", i), gd, vecs[i].exp_data);
      checkOutput($sformatf("vec%0d_syn", i), 32'(gs), 32'(vecs[i].exp_syn));
      checkOutput($sformatf("vec%0d_err", i), 32'(ge), 32'(vecs[i].exp_err));
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
    end

    // Stall: out_rdy low for 5 cycles while streaming 4 clean words.
    sent        = 0;
    rcvd        = 0;
    held        = '0;
    was_stalled = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      out_rdy = (c >= 5);
      if (c == 5) checkOutput("stall_accepted", 32'(sent), 32'd2);
      if (out_vld && out_rdy) begin
        if (rcvd < 4)
          checkOutput($sformatf("stall_word%0d", rcvd), out_data,
                      stall_data[rcvd]);
        rcvd++;
        was_stalled = 1'b0;
      end else if (out_vld) begin
        if (was_stalled) checkOutput("stall_hold", out_data, held);
        held        = out_data;
        was_stalled = 1'b1;
      end
      in_vld = (sent < 4);
      if (sent < 4) begin
        in_data = stall_data[sent];
        in_chk  = CHK_IN_W'(stall_chk[sent]);
        in_en   = 1'b1;
      end
      #1;
      acc = in_vld && in_rdy;
      @(posedge clk);
      if (acc) sent++;
    end
    @(negedge clk);
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    checkOutput("stall_count", 32'(rcvd), 32'd4);

    // Key load (to 10, NOR) starting while two words are in flight.
    @(negedge clk);
    out_rdy = 1'b0;
    in_vld  = 1'b1;
    in_data = 32'h00080000;
    in_chk  = CHK_IN_W'(6'd25);
    in_en   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_data = 32'h00080001;
    in_chk  = CHK_IN_W'(6'd26);
    @(posedge clk);
    @(negedge clk);
    in_vld  = 1'b0;
    key_vld = 1'b1;
    key_in  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    key_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_vld = 1'b0;
    #1;
    checkOutput("flight_key_busy", 32'(key_busy), 32'd1);
    checkOutput("flight_in_rdy",   32'(in_rdy),   32'd0);
    out_rdy = 1'b1;
    rx_n    = 0;
    rx[0]   = '0;
    rx[1]   = '0;
    for (int c = 0; c < 10; c++) begin
      if (out_vld) begin
        if (rx_n < 2) rx[rx_n] = out_data;
        rx_n++;
      end
      @(negedge clk);
    end
    checkOutput("flight_count", 32'(rx_n), 32'd2);
    checkOutput("flight_word0", rx[0], 32'h00080000);
    checkOutput("flight_word1", rx[1], 32'h00080001);
    waitc = 0;
    while (key_busy && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    #1;
    checkOutput("flight_key_done", 32'(key_busy), 32'd0);
    checkOutput("flight_rdy_back", 32'(in_rdy),   32'd1);

    // The new NOR key: 1 NOR 0 = 0, 0 NOR 0 = 1.
    applyStimulus(32'h00080000, 6'd25, 1'b1, gd, gs, ge, lat);
    checkOutput("nor_a1_data", gd, 32'h00000000);
    applyStimulus(32'h00000000, 6'd0, 1'b1, gd, gs, ge, lat);
    checkOutput("nor_a0_data", gd, 32'h00080000);

    // Reset in the middle of a load clears the active key back to NAND.
    @(negedge clk);
    key_vld = 1'b1;
    key_in  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_vld = 1'b0;
    #1;
    checkOutput("midload_busy", 32'(key_busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midload_reset_busy", 32'(key_busy), 32'd0);
    applyStimulus(32'h00000000, 6'd0, 1'b1, gd, gs, ge, lat);
    checkOutput("midload_nand00", gd, 32'h00080000);
    applyStimulus(32'h00080000, 6'd25, 1'b1, gd, gs, ge, lat);
    checkOutput("midload_nand10", gd, 32'h00080000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
